// File: rtl/imm_ext_pkg.sv
// Shared constants and types for the immediate-extension arbiter.
// Mode encodings, FSM state type and default widths.
package imm_ext_pkg;

    localparam int DEF_IMM_W  = 16;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/imm_ext_unit.sv
// Purely combinational immediate extender: zero, sign or upper-half placement.
// The reserved mode extends as ZERO and raises rsvd.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = DEF_IMM_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] data,
    output logic              rsvd
);

    always_comb begin
        data = {{(DATA_W-IMM_W){1'b0}}, imm};
        rsvd = 1'b0;
        case (mode)
            MODE_SIGN:  data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            MODE_UPPER: data = {imm, {(DATA_W-IMM_W){1'b0}}};
            MODE_RSVD:  rsvd = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin front end for a shared immediate extender,
// with a one-entry registered output stage that holds until consumed.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = DEF_IMM_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [IMM_W-1:0]  req_imm0,
    input  logic [IMM_W-1:0]  req_imm1,
    input  logic [1:0]        req_mode0,
    input  logic [1:0]        req_mode1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              mode_err
);

    // Handshake: a transfer occurs on a port in any cycle where valid and
    // ready are both high at the rising edge; ready never depends on data.
    state_t             state;
    logic               last_grant;
    logic               gnt_idx;
    logic               can_accept;
    logic               xfer;
    logic [IMM_W-1:0]   sel_imm;
    logic [1:0]         sel_mode;
    logic [DATA_W-1:0]  ext_data;
    logic               ext_rsvd;

    // On a tie the requester that did not win the last transfer goes next.
    always_comb begin
        gnt_idx = 1'b0;
        if (req_valid == 2'b11)
            gnt_idx = ~last_grant;
        else if (req_valid[1])
            gnt_idx = 1'b1;
    end

    assign can_accept = (state == EMPTY) | out_ready;
    assign xfer       = (|req_valid) & can_accept & ~rst;
    assign req_ready  = xfer ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    assign sel_imm  = gnt_idx ? req_imm1  : req_imm0;
    assign sel_mode = gnt_idx ? req_mode1 : req_mode0;

    imm_ext_unit #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_ext (
        .imm  (sel_imm),
        .mode (sel_mode),
        .data (ext_data),
        .rsvd (ext_rsvd)
    );

    assign out_valid = (state == FULL);

    // A new transfer in FULL with out_ready high replaces the held result at
    // the same edge, so back-to-back results leave no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
            mode_err   <= 1'b0;
        end else begin
            if (xfer) begin
                state      <= FULL;
                out_data   <= ext_data;
                out_src    <= gnt_idx;
                last_grant <= gnt_idx;
                if (ext_rsvd)
                    mode_err <= 1'b1;
            end else if (state == FULL && out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shared immediate-extension unit with a two-requester round-robin arbiter and a one-entry registered output stage. The instruction-decode stage (requester 0) and the load/store address unit (requester 1) each submit a 16-bit immediate plus an extension mode. The block grants one request per cycle, computes the 32-bit extended value, and holds it until the datapath consumer accepts it. It replaces the per-stage extenders in the execute front end.

## Interface
Parameters:
- IMM_W, 16, immediate input width
- DATA_W, 32, extended output width (must equal 2*IMM_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit 0 = decode, bit 1 = LSU
- req_ready  out  2  per-requester accept; a transfer happens on valid&ready
- req_imm0, req_imm1  in  IMM_W  immediate from requester 0 / 1
- req_mode0, req_mode1  in  2  extension mode from requester 0 / 1
- out_valid  out  1  extended result held in the output register
- out_ready  in  1  consumer accepts the result
- out_data  out  DATA_W  extended value
- out_src  out  1  index of the requester that produced out_data
- mode_err  out  1  sticky flag: a reserved mode was accepted

## Operation
- Mode encoding: 00 ZERO = {16'h0000, imm}; 01 SIGN = {{16{imm[15]}}, imm}; 10 UPPER = {imm, 16'h0000}; 11 reserved, computed as ZERO and sets mode_err.
- FSM states: EMPTY (no result held), FULL (result held, out_valid=1).
- can_accept = (state==EMPTY) | out_ready. Only the granted requester sees req_ready=1, and only when can_accept. The non-granted bit is 0.
- Arbitration: only one valid requester means it is granted. Both valid means the requester that is not last_grant wins. last_grant updates only on an actual transfer.
- Transfer: the output register loads {out_src, out_data} and the state becomes FULL.
- EMPTY→FULL on transfer. FULL→FULL on out_ready with a new transfer (back-to-back). FULL→EMPTY on out_ready with no transfer. FULL holds while out_ready=0.
- While FULL and out_ready=0, out_data and out_src are stable and req_ready=2'b00.
- req_ready is combinational from req_valid, state, out_ready and last_grant. There is no combinational path from req_imm/req_mode to any output.
- mode_err clears only on rst.

## Timing
- Reset (async assert, sync release): state=EMPTY, out_valid=0, out_data=0, out_src=0, last_grant=1 (requester 0 wins the first tie), mode_err=0, req_ready=0 while rst is high.
- Latency: accepted at edge N, so out_valid=1 with data after edge N.
- Throughput: 1 result per cycle when out_ready is held high.
- Simultaneous out_ready and a new transfer in FULL: old data is consumed and new data is loaded at the same edge, so there is no bubble.
- Fairness: with both requesters continuously valid and out_ready=1, grants strictly alternate 0,1,0,1…
- Reset asserted mid-operation: the held result is discarded immediately and no transfer is reported.

## Structure
- Package imm_ext_pkg holds the mode constants (MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_RSVD), the state typedef (EMPTY, FULL) and IMM_W/DATA_W defaults.
- Sub-module imm_ext_unit: a purely combinational extender (imm, mode → data, rsvd). It is instantiated once, after the grant mux.
- The arbiter, FSM and output register live in the top module.

## Test plan
- Reset, then a single request: req_valid=01, imm0=16'h8001, mode0=SIGN → req_ready=01 that cycle; next cycle out_valid=1, out_data=32'hFFFF8001, out_src=0.
- All modes on requester 1: imm1=16'h1234 with ZERO/SIGN/UPPER/RSVD → 32'h00001234, 32'h00001234, 32'h12340000, 32'h00001234; mode_err rises after RSVD and stays 1.
- Tie fairness: both valid for 6 cycles, out_ready=1 → grants 0,1,0,1,0,1; out_src follows one cycle later.
- Backpressure: result held, out_ready=0 for 3 cycles with both requesting → req_ready=00; out_data stable; raising out_ready gives a same-edge drain and load, with no bubble.
- Drain to empty: FULL, out_ready=1, req_valid=00 → out_valid=0 next cycle; out_data retains its last value.
- Async reset mid-stream: assert rst between edges while FULL → out_valid=0, mode_err=0, req_ready=00 immediately; after release a tie goes to requester 0.
